// File: rtl/vote_tally.sv
// Four-candidate ballot counter with an IDLE/OPEN/CLOSED election FSM.
// Per-candidate counters saturate with sticky flags, and the election auto-closes at VOTE_LIMIT.
module vote_tally #(
    parameter int         CNT_W      = 6,
    parameter logic [7:0] VOTE_LIMIT = 8'd100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             vote_valid,
    input  logic [1:0]       vote_id,
    output logic             vote_ready,
    output logic [CNT_W-1:0] VA,
    output logic [CNT_W-1:0] VB,
    output logic [CNT_W-1:0] VC,
    output logic [CNT_W-1:0] VD,
    output logic [7:0]       total,
    output logic [3:0]       sat,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, OPEN, CLOSED} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                 state_q, state_d;
    logic [3:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]             total_q, total_d;
    logic [3:0]             sat_q, sat_d;
    logic                   done_q, done_d;
    logic                   accept;

    assign vote_ready = (state_q == OPEN);
    assign accept     = vote_valid && vote_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE, CLOSED: begin
                if (start) begin
                    state_d = OPEN;
                    cnt_d   = '0;
                    total_d = '0;
                    sat_d   = '0;
                end
            end
            OPEN: begin
                // A saturated candidate still counts toward total but flags the overflow.
                if (accept) begin
                    if (cnt_q[vote_id] == CNT_MAX) begin
                        sat_d[vote_id] = 1'b1;
                    end else begin
                        cnt_d[vote_id] = cnt_q[vote_id] + CNT_W'(1);
                    end
                    total_d = total_q + 8'd1;
                end
                if (stop || (accept && (total_d == VOTE_LIMIT))) begin
                    state_d = CLOSED;
                end
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == CLOSED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            total_q <= '0;
            sat_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            sat_q   <= sat_d;
            done_q  <= done_d;
        end
    end

    assign VA    = cnt_q[0];
    assign VB    = cnt_q[1];
    assign VC    = cnt_q[2];
    assign VD    = cnt_q[3];
    assign total = total_q;
    assign sat   = sat_q;
    assign done  = done_q;

endmodule

// File: tb/tb_vote_tally.sv
// Self-checking bench for vote_tally: directed election scenarios plus a randomized run
// compared against an election-level reference model; a second instance uses VOTE_LIMIT=80.
module tb_vote_tally;

    logic       clk = 1'b0;
    logic       rst = 1'b1, start = 1'b0, stop = 1'b0, vote_valid = 1'b0;
    logic [1:0] vote_id = 2'd0;
    logic       vote_ready, done;
    logic [5:0] VA, VB, VC, VD;
    logic [7:0] total;
    logic [3:0] sat;

    logic       s_rst = 1'b1, s_start = 1'b0, s_stop = 1'b0, s_vote_valid = 1'b0;
    logic [1:0] s_vote_id = 2'd0;
    logic       s_vote_ready, s_done;
    logic [5:0] s_VA, s_VB, s_VC, s_VD;
    logic [7:0] s_total;
    logic [3:0] s_sat;

    logic [37:0] obs;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0 = idle, 1 = open, 2 = closed
    localparam int LIMIT = 100;
    localparam int CMAX  = 63;
    int       m_cnt[4];
    int       m_total;
    bit [3:0] m_sat;
    int       m_phase;

    vote_tally dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .vote_valid(vote_valid), .vote_id(vote_id), .vote_ready(vote_ready),
        .VA(VA), .VB(VB), .VC(VC), .VD(VD),
        .total(total), .sat(sat), .done(done)
    );

    vote_tally #(.CNT_W(6), .VOTE_LIMIT(8'd80)) dut_s (
        .clk(clk), .rst(s_rst), .start(s_start), .stop(s_stop),
        .vote_valid(s_vote_valid), .vote_id(s_vote_id), .vote_ready(s_vote_ready),
        .VA(s_VA), .VB(s_VB), .VC(s_VC), .VD(s_VD),
        .total(s_total), .sat(s_sat), .done(s_done)
    );

    always #5 clk = ~clk;

    assign obs = {VA, VB, VC, VD, total, sat, done, vote_ready};

    function automatic logic [37:0] expected_vec();
        return {6'(m_cnt[0]), 6'(m_cnt[1]), 6'(m_cnt[2]), 6'(m_cnt[3]),
                8'(m_total), m_sat, (m_phase == 2), (m_phase == 1)};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_total = 0;
        m_sat   = 4'b0000;
    endtask

    task automatic model_edge(input bit r, input bit s, input bit p, input bit v, input bit [1:0] id);
        if (r) begin
            model_clear();
            m_phase = 0;
        end else if (m_phase != 1) begin
            if (s) begin
                model_clear();
                m_phase = 1;
            end
        end else begin
            if (v) begin
                if (m_cnt[id] == CMAX) m_sat[id] = 1'b1;
                else m_cnt[id] = m_cnt[id] + 1;
                m_total = m_total + 1;
            end
            if (p || (v && m_total == LIMIT)) m_phase = 2;
        end
    endtask

    task automatic step(input bit r, input bit s, input bit p, input bit v, input bit [1:0] id);
        rst = r; start = s; stop = p; vote_valid = v; vote_id = id;
        @(posedge clk);
        model_edge(r, s, p, v, id);
        #1;
    endtask

    task automatic s_step(input bit r, input bit s, input bit p, input bit v, input bit [1:0] id);
        s_rst = r; s_start = s; s_stop = p; s_vote_valid = v; s_vote_id = id;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 2'd0);
        step(1, 1, 1, 1, 2'd1);
        checks++;
        if (obs !== 38'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: got %h expected %h", obs, 38'd0);
        end
        checks++;
        if (obs !== expected_vec()) begin
            failures++;
            $display("[TB] FAIL reset_model: got %h expected %h", obs, expected_vec());
        end
    endtask

    task automatic test_basic_tally();
        int plan[4] = '{17, 15, 15, 53};
        step(0, 1, 0, 0, 2'd0);
        checks++;
        if (vote_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_ready_open: got %b expected 1", vote_ready);
        end
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < plan[c]; k++) begin
                if ($urandom_range(3) == 0) step(0, 0, 0, 0, 2'd0);
                step(0, 0, 0, 1, 2'(c));
            end
        end
        checks++;
        if ({VA, VB, VC, VD, total} !== {6'd17, 6'd15, 6'd15, 6'd53, 8'd100}) begin
            failures++;
            $display("[TB] FAIL basic_counts: got %0d/%0d/%0d/%0d total %0d expected 17/15/15/53 total 100",
                     VA, VB, VC, VD, total);
        end
        checks++;
        if ({done, vote_ready} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL basic_autoclose: got done=%b ready=%b expected done=1 ready=0", done, vote_ready);
        end
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 2'(k));
        step(0, 0, 1, 0, 2'd0);
        checks++;
        if (total !== 8'd100 || obs !== expected_vec()) begin
            failures++;
            $display("[TB] FAIL basic_limit_hold: got %h expected %h", obs, expected_vec());
        end
    endtask

    task automatic test_stop_collision();
        step(1, 0, 0, 0, 2'd0);
        step(0, 1, 0, 0, 2'd0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 2'd2);
        checks++;
        if (VC !== 6'd4) begin
            failures++;
            $display("[TB] FAIL collision_pre: got VC=%0d expected 4", VC);
        end
        step(0, 0, 1, 1, 2'd2);
        checks++;
        if ({VC, done, vote_ready} !== {6'd5, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL collision_post: got VC=%0d done=%b ready=%b expected VC=5 done=1 ready=0",
                     VC, done, vote_ready);
        end
        step(0, 0, 0, 0, 2'd0);
        checks++;
        if (vote_ready !== 1'b0 || obs !== expected_vec()) begin
            failures++;
            $display("[TB] FAIL collision_after: got %h expected %h", obs, expected_vec());
        end
    endtask

    task automatic test_ignored_inputs();
        for (int k = 0; k < 6; k++) step(0, 0, 0, 1, 2'($urandom_range(3)));
        checks++;
        if (VC !== 6'd5 || total !== 8'd5 || obs !== expected_vec()) begin
            failures++;
            $display("[TB] FAIL ignored_closed: got %h expected %h", obs, expected_vec());
        end
        step(1, 0, 0, 0, 2'd0);
        for (int k = 0; k < 6; k++) step(0, 0, 0, 1, 2'($urandom_range(3)));
        checks++;
        if (obs !== 38'd0) begin
            failures++;
            $display("[TB] FAIL ignored_idle: got %h expected %h", obs, 38'd0);
        end
        step(0, 1, 0, 0, 2'd0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 2'd0);
        step(0, 1, 0, 1, 2'd1);
        checks++;
        if ({VA, VB, total, vote_ready} !== {6'd3, 6'd1, 8'd4, 1'b1}) begin
            failures++;
            $display("[TB] FAIL start_in_open: got VA=%0d VB=%0d total=%0d ready=%b expected 3/1/4/1",
                     VA, VB, total, vote_ready);
        end
        step(0, 1, 1, 0, 2'd0);
        checks++;
        if ({done, total} !== {1'b1, 8'd4}) begin
            failures++;
            $display("[TB] FAIL stop_wins_open: got done=%b total=%0d expected done=1 total=4", done, total);
        end
        step(0, 1, 1, 0, 2'd0);
        checks++;
        if (obs !== 38'd1) begin
            failures++;
            $display("[TB] FAIL start_wins_closed: got %h expected %h", obs, 38'd1);
        end
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 10; k++) step(0, 0, 0, 1, 2'($urandom_range(3)));
        checks++;
        if (total !== 8'd10 || obs !== expected_vec()) begin
            failures++;
            $display("[TB] FAIL mid_pre: got %h expected %h", obs, expected_vec());
        end
        step(1, 1, 0, 1, 2'd3);
        checks++;
        if (obs !== 38'd0) begin
            failures++;
            $display("[TB] FAIL mid_reset: got %h expected %h", obs, 38'd0);
        end
        step(0, 1, 0, 0, 2'd0);
        step(0, 0, 0, 1, 2'd3);
        checks++;
        if ({VD, total, done, vote_ready} !== {6'd1, 8'd1, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL mid_restart: got VD=%0d total=%0d done=%b ready=%b expected 1/1/0/1",
                     VD, total, done, vote_ready);
        end
    endtask

    task automatic test_reopen();
        step(1, 0, 0, 0, 2'd0);
        step(0, 1, 0, 0, 2'd0);
        for (int k = 0; k < 9; k++) step(0, 0, 0, 1, 2'd0);
        step(0, 0, 1, 0, 2'd0);
        checks++;
        if ({VA, done} !== {6'd9, 1'b1}) begin
            failures++;
            $display("[TB] FAIL reopen_pre: got VA=%0d done=%b expected VA=9 done=1", VA, done);
        end
        step(0, 1, 0, 0, 2'd0);
        checks++;
        if (obs !== 38'd1) begin
            failures++;
            $display("[TB] FAIL reopen: got %h expected %h", obs, 38'd1);
        end
    endtask

    task automatic test_saturation();
        s_step(1, 0, 0, 0, 2'd0);
        s_step(0, 1, 0, 0, 2'd0);
        for (int k = 0; k < 70; k++) s_step(0, 0, 0, 1, 2'd0);
        s_step(0, 0, 1, 0, 2'd0);
        checks++;
        if ({s_VA, s_sat, s_total, s_done} !== {6'd63, 4'b0001, 8'd70, 1'b1}) begin
            failures++;
            $display("[TB] FAIL sat_a: got VA=%0d sat=%b total=%0d done=%b expected 63/0001/70/1",
                     s_VA, s_sat, s_total, s_done);
        end
        s_step(0, 1, 0, 0, 2'd0);
        checks++;
        if ({s_VA, s_sat, s_total} !== {6'd0, 4'b0000, 8'd0}) begin
            failures++;
            $display("[TB] FAIL sat_clear: got VA=%0d sat=%b total=%0d expected 0/0000/0", s_VA, s_sat, s_total);
        end
        for (int k = 0; k < 79; k++) s_step(0, 0, 0, 1, 2'd1);
        checks++;
        if ({s_total, s_done, s_vote_ready} !== {8'd79, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL limit_minus_one: got total=%0d done=%b ready=%b expected 79/0/1",
                     s_total, s_done, s_vote_ready);
        end
        s_step(0, 0, 0, 1, 2'd1);
        checks++;
        if ({s_VB, s_sat, s_total, s_done} !== {6'd63, 4'b0010, 8'd80, 1'b1}) begin
            failures++;
            $display("[TB] FAIL limit_close: got VB=%0d sat=%b total=%0d done=%b expected 63/0010/80/1",
                     s_VB, s_sat, s_total, s_done);
        end
    endtask

    task automatic test_random();
        bit       r, s, p, v;
        bit [1:0] id;
        step(1, 0, 0, 0, 2'd0);
        for (int n = 0; n < 1500; n++) begin
            r  = ($urandom_range(199) == 0);
            s  = ($urandom_range(24) == 0);
            p  = ($urandom_range(39) == 0);
            v  = ($urandom_range(3) != 0);
            id = ($urandom_range(1) == 0) ? 2'd0 : 2'($urandom_range(3));
            step(r, s, p, v, id);
            checks++;
            if (obs !== expected_vec()) begin
                failures++;
                $display("[TB] FAIL random_cycle_%0d: got %h expected %h", n, obs, expected_vec());
            end
        end
    endtask

    initial begin
        model_clear();
        m_phase = 0;
        test_reset();
        test_basic_tally();
        test_stop_collision();
        test_ignored_inputs();
        test_mid_reset();
        test_reopen();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vote_tally.md
VOTE_TALLY -- requirements
Module: vote_tally

Interface
REQ-001 Parameter CNT_W, default 6: per-candidate counter width, matching the 6-bit vote buses consumed by the decision stage.
REQ-002 Parameter VOTE_LIMIT, default 8'd100: total accepted votes at which the election auto-closes; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to open a new election.
REQ-006 stop  input  1  single-cycle request to close the running election.
REQ-007 vote_valid  input  1  a ballot is presented this cycle.
REQ-008 vote_id  input  2  ballot target: 00=A, 01=B, 10=C, 11=D.
REQ-009 vote_ready  output  1  block accepts a ballot this cycle.
REQ-010 VA, VB, VC, VD  output  CNT_W each  per-candidate tallies for A, B, C, D.
REQ-011 total  output  8  count of accepted ballots in the current election.
REQ-012 sat  output  4  sticky saturation flags: bit0=A, bit1=B, bit2=C, bit3=D.
REQ-013 done  output  1  election closed; VA..VD final and stable.

Function
REQ-014 FSM states are IDLE, OPEN and CLOSED; reset enters IDLE.
REQ-015 IDLE: start=1 -> OPEN, clearing VA..VD, total and sat on the same edge; otherwise stay.
REQ-016 OPEN: stop=1 -> CLOSED; total reaching VOTE_LIMIT on an acceptance -> CLOSED on that same edge; otherwise stay.
REQ-017 CLOSED: start=1 -> OPEN with counters cleared as in REQ-015; otherwise hold all outputs.
REQ-018 vote_ready is combinational: 1 only in OPEN.
REQ-019 A ballot is accepted when vote_valid && vote_ready; the selected counter and total increment on that edge (1-cycle latency).
REQ-020 vote_valid outside OPEN is ignored, with no state change and no error.
REQ-021 Each candidate counter saturates at 2^CNT_W-1.
- A ballot for a saturated candidate leaves that counter unchanged.
- total still increments on such a ballot.
- The candidate's sat bit is set.
REQ-022 sat bits clear only on reset or on the start-driven clear.
REQ-023 A ballot accepted in the same cycle as stop is counted; the FSM then enters CLOSED.
REQ-024 start asserted in OPEN is ignored; if start and stop are both asserted in OPEN, stop wins.
REQ-025 start and stop both asserted in IDLE or CLOSED: start wins.
REQ-026 done = 1 exactly while in CLOSED; it is a registered state decode, with no combinational path from any input.
REQ-027 total never exceeds VOTE_LIMIT.
REQ-028 Sum of VA..VD equals total whenever sat = 0.

Reset
REQ-029 While rst=1, the following hold from the next edge:
- State = IDLE.
- VA = VB = VC = VD = 0, total = 0, sat = 0.
- done = 0, vote_ready = 0.
REQ-030 rst has priority over start, stop and vote_valid in every state, including mid-election; a ballot presented in a reset cycle is lost.

Verification
REQ-031 Basic tally:
- Stimulus: reset, start, then ballots A x17, B x15, C x15, D x53, then stop.
- Required response: VA=17, VB=15, VC=15, VD=53, total=100.
- The election auto-closes on the 100th ballot (default VOTE_LIMIT=100), so done=1 before stop.
REQ-032 Saturation:
- Stimulus: VOTE_LIMIT=80; 70 ballots for A, then stop.
- Required response: VA=63, sat=4'b0001, total=70, done=1.
REQ-033 Stop collision:
- Stimulus: a ballot for C presented in the same cycle as stop, with VC=4 beforehand.
- Required response: VC=5, done=1 on the next cycle, vote_ready=0 afterwards.
REQ-034 Ignored inputs:
- Stimulus: vote_valid held high in IDLE and in CLOSED.
- Required response: all counters unchanged; start asserted in OPEN has no effect.
REQ-035 Mid-election reset:
- Stimulus: rst pulsed after 10 ballots.
- Required response: all outputs return to the REQ-029 values; a new start restarts the tally from 0.
REQ-036 Re-open:
- Stimulus: start asserted in CLOSED with VA=9.
- Required response: VA..VD=0, total=0, sat=0, done=0, vote_ready=1 on the next cycle.
